// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I control path.
// MULTICYCLE_CTRL_JAL_EN adds the JAL state to the FSM.
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
`ifdef MULTICYCLE_CTRL_JAL_EN
    S_JAL,
`endif
    S_BEQ
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALU_OP_ADD  = 2'b00;
  localparam logic [1:0] ALU_OP_SUB  = 2'b01;
  localparam logic [1:0] ALU_OP_FUNC = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decoder for the multicycle control path.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    unique case (alu_op)
      ALU_OP_ADD: alu_control = ALU_ADD;
      ALU_OP_SUB: alu_control = ALU_SUB;
      ALU_OP_FUNC: begin
        unique case (funct3)
          // funct7b5 only selects sub for R-type; addi ignores it.
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM sequencing the shared multicycle RV32I datapath.
// MULTICYCLE_CTRL_JAL_EN enables jal; otherwise jal decodes as illegal.
module multicycle_ctrl
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal_instr,
  output logic       instr_retire
);

  state_t     state, state_nxt;
  logic       pc_update, branch;
  logic [1:0] alu_op;

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    unique case (op)
      OP_LW, OP_I: imm_src = IMM_I;
      OP_SW:       imm_src = IMM_S;
      OP_BEQ:      imm_src = IMM_B;
`ifdef MULTICYCLE_CTRL_JAL_EN
      OP_JAL:      imm_src = IMM_J;
`endif
      default:     imm_src = IMM_I;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    pc_update     = 1'b0;
    branch        = 1'b0;
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALU_OP_ADD;
    illegal_instr = 1'b0;
    instr_retire  = 1'b0;
    // Reset shows FETCH selects but suppresses every write and pulse.
    if (rst) begin
      alu_src_b  = SRCB_FOUR;
      result_src = RES_ALU;
    end else begin
      unique case (state)
        S_FETCH: begin
          ir_write   = 1'b1;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALU;
          pc_update  = 1'b1;
          state_nxt  = S_DECODE;
        end
        S_DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          unique case (op)
            OP_LW, OP_SW: state_nxt = S_MEM_ADR;
            OP_R:         state_nxt = S_EXEC_R;
            OP_I:         state_nxt = S_EXEC_I;
            OP_BEQ:       state_nxt = S_BEQ;
`ifdef MULTICYCLE_CTRL_JAL_EN
            OP_JAL:       state_nxt = S_JAL;
`endif
            default: begin
              illegal_instr = 1'b1;
              instr_retire  = 1'b1;
              state_nxt     = S_FETCH;
            end
          endcase
        end
        S_MEM_ADR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          state_nxt = op[5] ? S_MEM_WRITE : S_MEM_READ;
        end
        S_MEM_READ: begin
          adr_src   = 1'b1;
          state_nxt = S_MEM_WB;
        end
        S_MEM_WB: begin
          result_src   = RES_RDATA;
          reg_write    = 1'b1;
          instr_retire = 1'b1;
          state_nxt    = S_FETCH;
        end
        S_MEM_WRITE: begin
          adr_src      = 1'b1;
          mem_write    = 1'b1;
          instr_retire = 1'b1;
          state_nxt    = S_FETCH;
        end
        S_EXEC_R: begin
          alu_src_a = SRCA_RS1;
          alu_op    = ALU_OP_FUNC;
          state_nxt = S_ALU_WB;
        end
        S_EXEC_I: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALU_OP_FUNC;
          state_nxt = S_ALU_WB;
        end
        S_ALU_WB: begin
          reg_write    = 1'b1;
          instr_retire = 1'b1;
          state_nxt    = S_FETCH;
        end
        S_BEQ: begin
          alu_src_a    = SRCA_RS1;
          alu_op       = ALU_OP_SUB;
          branch       = 1'b1;
          instr_retire = 1'b1;
          state_nxt    = S_FETCH;
        end
`ifdef MULTICYCLE_CTRL_JAL_EN
        S_JAL: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_FOUR;
          pc_update = 1'b1;
          state_nxt = S_ALU_WB;
        end
`endif
        default: state_nxt = S_FETCH;
      endcase
    end
  end

  assign pc_write = pc_update | (branch & zero);

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (alu_control)
  );

endmodule
